mixcolumns256_iter: RTL

Iterative MixColumns stage for the 256-bit-block (Nb = 8) Rijndael encryption datapath. It sits directly downstream of the row-shift stage and consumes its 256-bit state. It transforms one 32-bit column per clock through a single shared column mixer, and returns the state over a valid/ready handshake. A per-block bypass flag passes the state through unchanged for the final round, which has no MixColumns.

---
 rtl/aes256_pkg.sv | 44 ++++
 rtl/mixcolumn32.sv | 28 ++
 rtl/mixcolumns256_iter.sv | 84 ++++++++
 3 files changed

// File: rtl/aes256_pkg.sv
// Shared types and byte-layout helpers for the 256-bit-block Rijndael datapath.
// Byte (r,c) lives at bits [255-64r-8c -: 8]; a column packs rows 0..3 MSB-first.
package aes256_pkg;

  localparam int NB      = 8;
  localparam int NR      = 14;
  localparam int STATE_W = 256;

  typedef logic [STATE_W-1:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mix_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] get_col(input state_t s, input logic [2:0] idx);
    logic [31:0] col;
    int base;
    col = '0;
    for (int r = 0; r < 4; r++) begin
      base = 255 - 64 * r - 8 * int'(idx);
      col[31 - 8 * r -: 8] = s[base -: 8];
    end
    return col;
  endfunction

  function automatic state_t put_col(input state_t s, input logic [2:0] idx,
                                     input logic [31:0] col);
    state_t res;
    int base;
    res = s;
    for (int r = 0; r < 4; r++) begin
      base = 255 - 64 * r - 8 * int'(idx);
      res[base -: 8] = col[31 - 8 * r -: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mixcolumn32.sv
// Combinational single-column MixColumns over GF(2^8) with polynomial 0x11B.
module mixcolumn32
  import aes256_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] s0, s1, s2, s3;
  logic [7:0] x0, x1, x2, x3;

  assign s0 = col_in[31:24];
  assign s1 = col_in[23:16];
  assign s2 = col_in[15:8];
  assign s3 = col_in[7:0];

  assign x0 = xtime(s0);
  assign x1 = xtime(s1);
  assign x2 = xtime(s2);
  assign x3 = xtime(s3);

  // 3*b is xtime(b) ^ b
  assign col_out[31:24] = x0 ^ (x1 ^ s1) ^ s2 ^ s3;
  assign col_out[23:16] = s0 ^ x1 ^ (x2 ^ s2) ^ s3;
  assign col_out[15:8]  = s0 ^ s1 ^ x2 ^ (x3 ^ s3);
  assign col_out[7:0]   = (x0 ^ s0) ^ s1 ^ s2 ^ x3;

endmodule

// File: rtl/mixcolumns256_iter.sv
// Iterative MixColumns for Nb = 8: one column per clock through a shared mixer,
// with a per-block bypass for the final round.
module mixcolumns256_iter
  import aes256_pkg::*;
#(
  parameter int NB_P = NB
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_state,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_state,
  output mix_state_e   dbg_state
);

  // Handshake: a transfer happens on an edge where valid and ready are both 1.
  // in_ready is high only in IDLE; out_valid is high only in DONE, and the
  // result stays stable until out_ready is seen.

  mix_state_e  state;
  logic [2:0]  col;
  state_t      work;
  logic [31:0] col_cur;
  logic [31:0] col_mixed;

  assign col_cur = get_col(work, col);

  mixcolumn32 u_mix (
    .col_in  (col_cur),
    .col_out (col_mixed)
  );

  // Gated by rst_n so upstream never sees ready while reset is held.
  assign in_ready  = rst_n && (state == ST_IDLE);
  assign out_state = work;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      col       <= 3'd0;
      work      <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            work <= in_state;
            col  <= 3'd0;
            if (in_last) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          work <= put_col(work, col, col_mixed);
          col  <= col + 3'd1;
          if (col == 3'(NB_P - 1)) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
